serial_addsub: RTL and testbench

- Parametrised, digit-serial two's-complement adder/subtractor with valid/ready handshakes on input and output.
- Generalises the fixed 4-bit ripple subtractor in three ways: WIDTH-bit operands, add/sub mode, and DIGIT bits processed per clock.
- Also reports carry, borrow, signed overflow and zero flags.
- Sits between an operand source and a result consumer in the datapath, trading latency for area.

---
 rtl/serial_addsub.sv | 161 ++++++++++++++++
 tb/tb_serial_addsub.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// Digit-serial two's-complement adder/subtractor, DIGIT bits per clock,
// with valid/ready on both sides and carry/borrow/overflow/zero flags.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | one DIGIT-bit slice summed per clock, N clocks total
// DONE  | result and flags presented, held until out_ready
module serial_addsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             borrow,
    output logic             ovf,
    output logic             zero
);

    generate
        if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
            $error("serial_addsub: DIGIT must divide WIDTH exactly");
        end
    endgenerate

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_accept;
    logic              w_last;

    logic [CW-1:0]     r_cnt;
    logic              r_carry;
    logic              r_sub;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_acc;
    logic [WIDTH-1:0]  r_result;
    logic              r_cout;
    logic              r_borrow;
    logic              r_ovf;
    logic              r_zero;

    logic [DIGIT:0]    w_dsum;
    logic              w_cmsb;
    logic [WIDTH-1:0]  w_acc_nxt;
    logic [WIDTH-1:0]  w_a_shift;
    logic [WIDTH-1:0]  w_b_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (r_cnt == LAST) begin
                    w_last      = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_dsum = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                  + {{DIGIT{1'b0}}, r_carry};
    // Carry into the top bit of the slice recovered from sum = a ^ b ^ cin.
    assign w_cmsb = w_dsum[DIGIT-1] ^ r_a[DIGIT-1] ^ r_b[DIGIT-1];

    generate
        if (N == 1) begin : g_single
            assign w_acc_nxt = w_dsum[DIGIT-1:0];
            assign w_a_shift = '0;
            assign w_b_shift = '0;
        end else begin : g_multi
            assign w_acc_nxt = {w_dsum[DIGIT-1:0], r_acc[WIDTH-1:DIGIT]};
            assign w_a_shift = {{DIGIT{1'b0}}, r_a[WIDTH-1:DIGIT]};
            assign w_b_shift = {{DIGIT{1'b0}}, r_b[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_sub    <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_sub   <= sub;
            r_carry <= sub;
            r_cnt   <= '0;
            r_acc   <= '0;
        end else if (r_state == RUN) begin
            r_a     <= w_a_shift;
            r_b     <= w_b_shift;
            r_acc   <= w_acc_nxt;
            r_carry <= w_dsum[DIGIT];
            r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
            // Output registers only move on the final slice, so a partial sum is never visible.
            if (w_last) begin
                r_result <= w_acc_nxt;
                r_cout   <= w_dsum[DIGIT];
                r_borrow <= r_sub & ~w_dsum[DIGIT];
                r_ovf    <= w_cmsb ^ w_dsum[DIGIT];
                r_zero   <= (w_acc_nxt == '0);
            end
        end
    end

    assign result = r_result;
    assign cout   = r_cout;
    assign borrow = r_borrow;
    assign ovf    = r_ovf;
    assign zero   = r_zero;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: three instances (DIGIT=2, 1, 8) share
// stimulus; each is checked for latency, result, flags and handshakes.
module tb_serial_addsub;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;

    logic       ir  [3];
    logic       ov  [3];
    logic [7:0] res [3];
    logic       co  [3];
    logic       bo  [3];
    logic       of  [3];
    logic       ze  [3];

    int n_chk;
    int n_err;
    int lat [3];
    int exp_lat [3];

    serial_addsub #(.WIDTH(8), .DIGIT(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
        .a(a), .b(b), .sub(sub), .out_valid(ov[0]), .out_ready(out_ready),
        .result(res[0]), .cout(co[0]), .borrow(bo[0]), .ovf(of[0]), .zero(ze[0]));

    serial_addsub #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
        .a(a), .b(b), .sub(sub), .out_valid(ov[1]), .out_ready(out_ready),
        .result(res[1]), .cout(co[1]), .borrow(bo[1]), .ovf(of[1]), .zero(ze[1]));

    serial_addsub #(.WIDTH(8), .DIGIT(8)) u_d8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
        .a(a), .b(b), .sub(sub), .out_valid(ov[2]), .out_ready(out_ready),
        .result(res[2]), .cout(co[2]), .borrow(bo[2]), .ovf(of[2]), .zero(ze[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string nm, input logic [7:0] er,
                             input logic ec, input logic eb, input logic eo, input logic ez);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s result[%0d]", nm, i), 32'(res[i]), 32'(er));
            chk($sformatf("%s cout[%0d]", nm, i),   32'(co[i]),  32'(ec));
            chk($sformatf("%s borrow[%0d]", nm, i), 32'(bo[i]),  32'(eb));
            chk($sformatf("%s ovf[%0d]", nm, i),    32'(of[i]),  32'(eo));
            chk($sformatf("%s zero[%0d]", nm, i),   32'(ze[i]),  32'(ez));
        end
    endtask

    task automatic do_op(input string nm, input logic [7:0] va, input logic [7:0] vb,
                         input logic vs, input logic [7:0] er, input logic ec,
                         input logic eb, input logic eo, input logic ez,
                         input int hold, input bit iso);
        @(negedge clk);
        for (int i = 0; i < 3; i++)
            chk($sformatf("%s idle in_ready[%0d]", nm, i), 32'(ir[i]), 32'd1);
        a = va; b = vb; sub = vs; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        if (iso) begin
            a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
        end
        for (int i = 0; i < 3; i++) lat[i] = 0;
        for (int j = 1; j <= 12; j++) begin
            @(posedge clk);
            @(negedge clk);
            for (int i = 0; i < 3; i++)
                if (ov[i] && lat[i] == 0) lat[i] = j;
            if (iso) begin
                a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
                in_valid = j[0];
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s latency[%0d]", nm, i), 32'(lat[i]), 32'(exp_lat[i]));
            chk($sformatf("%s busy in_ready[%0d]", nm, i), 32'(ir[i]), 32'd0);
        end
        chk_flags(nm, er, ec, eb, eo, ez);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("%s hold out_valid[%0d]", nm, i), 32'(ov[i]), 32'd1);
                chk($sformatf("%s hold in_ready[%0d]", nm, i), 32'(ir[i]), 32'd0);
            end
            chk_flags($sformatf("%s hold", nm), er, ec, eb, eo, ez);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s drain out_valid[%0d]", nm, i), 32'(ov[i]), 32'd0);
            chk($sformatf("%s drain in_ready[%0d]", nm, i), 32'(ir[i]), 32'd1);
        end
        chk_flags($sformatf("%s after", nm), er, ec, eb, eo, ez);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        exp_lat[0] = 4;
        exp_lat[1] = 8;
        exp_lat[2] = 1;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = 8'h00; b = 8'h00; sub = 1'b0;

        // Operands offered during reset must not be taken.
        repeat (2) @(negedge clk);
        a = 8'h12; b = 8'h34; in_valid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst out_valid[%0d]", i), 32'(ov[i]), 32'd0);
            chk($sformatf("rst in_ready[%0d]", i),  32'(ir[i]), 32'd1);
        end
        chk_flags("rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++)
            chk($sformatf("post-rst out_valid[%0d]", i), 32'(ov[i]), 32'd0);

        do_op("sub5-3",  8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        do_op("sub3-5",  8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        do_op("add7F+1", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        do_op("sub80-1", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        do_op("addFF+1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 10, 1'b0);
        do_op("iso40-10", 8'h40, 8'h10, 1'b1, 8'h30, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1);

        // Reset during the second RUN cycle; DIGIT=8 instance is already in DONE.
        @(negedge clk);
        a = 8'h11; b = 8'h22; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("midrst out_valid[%0d]", i), 32'(ov[i]), 32'd0);
            chk($sformatf("midrst in_ready[%0d]", i),  32'(ir[i]), 32'd1);
        end
        chk_flags("midrst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("add0A+5", 8'h0A, 8'h05, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
